// File: rtl/ifetch_prefetch_buffer_if.sv
// Bus bundle for the instruction prefetch stage: redirect, memory req/gnt/rvalid, and instruction valid/ready.
interface ifetch_prefetch_buffer_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetcher: credit-limited fetch issue, in-order word FIFO, redirect flush with drop count.
module ifetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic                      clk,
  input logic                      rst,
  ifetch_prefetch_buffer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   out_pc;
  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW:0]   in_use;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] count_nxt;
  logic [63:0]   target_pc;
  logic          grant;
  logic          resp;
  logic          drop_resp;
  logic          push;
  logic          pop;

  always_comb begin
    in_use    = {1'b0, count} + {1'b0, outstanding};
    target_pc = bus.redirect_pc & ~64'h3;
    grant     = bus.mem_req & bus.mem_gnt;
    // A stray rvalid with nothing outstanding is ignored so the counters never underflow.
    resp      = bus.mem_rvalid & (outstanding != '0);
    drop_resp = resp & (drop != '0);
    push      = resp & ~drop_resp & ~bus.redirect_valid;
    pop       = bus.instr_valid & bus.instr_ready & ~bus.redirect_valid;
    outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
    count_nxt       = count + CW'(push) - CW'(pop);
  end

  assign bus.mem_req     = rst & (in_use < DEPTH_W);
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_pc    = out_pc;
  assign bus.instr_data  = bus.instr_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      out_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle, including a same-cycle grant, is discarded on return.
        fetch_pc <= target_pc;
        out_pc   <= target_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= outstanding_nxt;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + 64'd4;
        if (drop_resp) drop     <= drop - 1'b1;
        if (push)      wr_ptr   <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          out_pc <= out_pc + 64'd4;
        end
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Scoreboard bench for ifetch_prefetch_buffer: directed phases push expected PCs, a monitor checks every pop.
module tb_ifetch_prefetch_buffer;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_prefetch_buffer_if bif();

  ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int          checks    = 0;
  int          errors    = 0;
  int          grant_cnt = 0;
  bit          gnt_en    = 1'b0;
  bit          hold_resp = 1'b0;
  logic [63:0] exp_pc_q[$];
  logic [31:0] exp_data_q[$];
  logic [63:0] pend_q[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    exp_pc_q.push_back(pc);
    exp_data_q.push_back(mem_word(pc));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Memory: grants when gnt_en, answers in order one cycle later unless hold_resp.
  initial begin
    bif.mem_gnt    = 1'b0;
    bif.mem_rvalid = 1'b0;
    bif.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pend_q.delete();
        bif.mem_gnt    = 1'b0;
        bif.mem_rvalid = 1'b0;
        bif.mem_rdata  = '0;
      end else begin
        if (pend_q.size() > 0 && !hold_resp) begin
          bif.mem_rvalid = 1'b1;
          bif.mem_rdata  = mem_word(pend_q.pop_front());
        end else begin
          bif.mem_rvalid = 1'b0;
          bif.mem_rdata  = '0;
        end
        bif.mem_gnt = gnt_en;
        if (bif.mem_req && gnt_en) begin
          pend_q.push_back(bif.mem_addr);
          grant_cnt++;
        end
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst && bif.instr_valid && bif.instr_ready && !bif.redirect_valid) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h, expected no output", bif.instr_pc);
        end else begin
          check("out_pc", bif.instr_pc, exp_pc_q.pop_front());
          check("out_data", {32'h0, bif.instr_data}, {32'h0, exp_data_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [63:0] nxt;
    int          g0;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc    = '0;
    bif.instr_ready    = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_mem_req", 64'(bif.mem_req), 64'd0);
    check("rst_mem_addr", bif.mem_addr, RPC);
    check("rst_instr_valid", 64'(bif.instr_valid), 64'd0);
    check("rst_instr_data", {32'h0, bif.instr_data}, 64'd0);
    check("rst_instr_pc", bif.instr_pc, RPC);
    repeat (2) cyc();

    // Streaming from reset, PCs wrap through zero.
    rst             = 1'b1;
    gnt_en          = 1'b1;
    bif.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(RPC + 64'(4 * i));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      if (c == 8) gnt_en = 1'b0;
      #4;
      if (c == 0) begin
        check("a_first_req", 64'(bif.mem_req), 64'd1);
        check("a_first_addr", bif.mem_addr, RPC);
      end
      check("a_valid", 64'(bif.instr_valid), 64'((c >= 2 && c <= 9)));
    end
    check("a_drain", 64'(exp_pc_q.size()), 64'd0);
    check("a_idle_data", {32'h0, bif.instr_data}, 64'd0);
    nxt = 64'h18;

    // Back-pressure: credits stop issue after DEPTH words.
    cyc();
    bif.instr_ready = 1'b0;
    gnt_en          = 1'b1;
    g0              = grant_cnt;
    for (int i = 0; i < 4; i++) expect_pc(nxt + 64'(4 * i));
    repeat (8) cyc();
    #4;
    check("b_grants", 64'(grant_cnt - g0), 64'd4);
    check("b_req_off", 64'(bif.mem_req), 64'd0);
    check("b_full_valid", 64'(bif.instr_valid), 64'd1);
    cyc();
    bif.instr_ready = 1'b1;
    gnt_en          = 1'b0;
    #4;
    check("b_req_first_pop", 64'(bif.mem_req), 64'd0);
    cyc();
    #4;
    check("b_req_after_pop", 64'(bif.mem_req), 64'd1);
    repeat (3) cyc();
    #4;
    check("b_drain", 64'(exp_pc_q.size()), 64'd0);
    check("b_empty", 64'(bif.instr_valid), 64'd0);
    nxt = nxt + 64'd16;

    // Grant stall: address held, then advances by one word.
    for (int i = 0; i < 5; i++) begin
      cyc();
      #4;
      check("c_req_stall", 64'(bif.mem_req), 64'd1);
      check("c_addr_stall", bif.mem_addr, nxt);
    end
    cyc();
    gnt_en = 1'b1;
    expect_pc(nxt);
    cyc();
    gnt_en = 1'b0;
    #4;
    check("c_addr_adv", bif.mem_addr, nxt + 64'd4);
    repeat (3) cyc();
    #4;
    check("c_drain", 64'(exp_pc_q.size()), 64'd0);

    // Redirect with three requests in flight; unaligned target.
    cyc();
    hold_resp = 1'b1;
    gnt_en    = 1'b1;
    repeat (3) cyc();
    gnt_en             = 1'b0;
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 64'h1002;
    cyc();
    bif.redirect_valid = 1'b0;
    hold_resp          = 1'b0;
    gnt_en             = 1'b1;
    expect_pc(64'h1000);
    expect_pc(64'h1004);
    #4;
    check("d_req", 64'(bif.mem_req), 64'd1);
    check("d_addr", bif.mem_addr, 64'h1000);
    check("d_valid_t1", 64'(bif.instr_valid), 64'd0);
    for (int c = 2; c <= 8; c++) begin
      cyc();
      if (c == 3) gnt_en = 1'b0;
      #4;
      if (c <= 4) check("d_valid_dropped", 64'(bif.instr_valid), 64'd0);
      if (c == 5) check("d_first_pc", bif.instr_pc, 64'h1000);
    end
    check("d_drain", 64'(exp_pc_q.size()), 64'd0);

    // Redirect coinciding with grant, response and pop.
    cyc();
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 64'h2000;
    cyc();
    bif.redirect_valid = 1'b0;
    gnt_en             = 1'b1;
    expect_pc(64'h2000);
    expect_pc(64'h2004);
    expect_pc(64'h2008);
    repeat (5) cyc();
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 64'h3000;
    #4;
    check("e_busy_valid", 64'(bif.instr_valid), 64'd1);
    check("e_busy_req", 64'(bif.mem_req), 64'd1);
    check("e_pre_drain", 64'(exp_pc_q.size()), 64'd0);
    cyc();
    bif.redirect_valid = 1'b0;
    expect_pc(64'h3000);
    expect_pc(64'h3004);
    #4;
    check("e_flushed", 64'(bif.instr_valid), 64'd0);
    check("e_addr", bif.mem_addr, 64'h3000);
    cyc();
    #4;
    check("e_dropped", 64'(bif.instr_valid), 64'd0);
    cyc();
    gnt_en = 1'b0;
    #4;
    check("e_first_valid", 64'(bif.instr_valid), 64'd1);
    check("e_first_pc", bif.instr_pc, 64'h3000);
    repeat (3) cyc();
    #4;
    check("e_drain", 64'(exp_pc_q.size()), 64'd0);

    // Reset in the middle of traffic.
    cyc();
    gnt_en = 1'b1;
    repeat (2) cyc();
    rst    = 1'b0;
    gnt_en = 1'b0;
    #1;
    check("f_req", 64'(bif.mem_req), 64'd0);
    check("f_valid", 64'(bif.instr_valid), 64'd0);
    check("f_addr", bif.mem_addr, RPC);
    check("f_pc", bif.instr_pc, RPC);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch_buffer.md
# ifetch_prefetch_buffer

Instruction prefetch stage directly upstream of the core's instruction port. Issues sequential 32-bit fetches on a req/gnt/rvalid memory bus, buffers returned words in a small in-order FIFO, and presents them with their PCs on a valid/ready interface. A single-cycle redirect flushes the buffer, discards in-flight responses, and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries and maximum outstanding-plus-buffered words; power of two, ≥2.
- RESET_PC, 64'h0: first fetch address after reset; bits [1:0] must be 0.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low; one clock domain.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  64  restart PC; bits [1:0] forced to 0 internally.
- mem_req  out  1  fetch request.
- mem_addr  out  64  fetch address; stable while mem_req=1 and mem_gnt=0, except on redirect.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response word valid; responses in grant order, earliest the cycle after gnt.
- mem_rdata  in  32  response word.
- instr_valid  out  1  instr_data/instr_pc valid.
- instr_ready  in  1  consumer accepts this cycle.
- instr_data  out  32  instruction word; 32'h0 whenever instr_valid=0.
- instr_pc  out  64  PC of instr_data.

## Operation
- State: fetch_pc (64b), out_pc (64b), FIFO of DEPTH×32b with rd/wr pointers and count (clog2(DEPTH)+1 bits), outstanding counter (same width), drop counter (same width).
- Issue: mem_req=1 iff count + outstanding < DEPTH and not in reset; mem_addr=fetch_pc.
- Grant (mem_req & mem_gnt): fetch_pc += 4 (modulo 2^64, wraps FFFF_FFFF_FFFF_FFFC→0); outstanding += 1.
- Response (mem_rvalid): outstanding −= 1; if drop>0 then drop −= 1 and word discarded, else word pushed to FIFO.
- Pop (instr_valid & instr_ready): rd pointer advances, count −= 1, out_pc += 4 (modulo 2^64).
- instr_valid = (count != 0); instr_pc = out_pc; instr_data = FIFO head.
- Redirect (redirect_valid=1), highest priority:
  - FIFO emptied (count=0, pointers reset), pop that cycle ignored.
  - fetch_pc and out_pc ← {redirect_pc[63:2],2'b00}.
  - drop ← outstanding after this cycle's grant/response accounting (a same-cycle grant is counted and dropped; a same-cycle non-dropped response is discarded, not pushed).
  - mem_addr may change in the redirect cycle even if the prior request was not granted; the bus tolerates this abort.
- Simultaneous push and pop with count=DEPTH cannot occur (credit rule guarantees space); push and pop at any other count: count unchanged.
- rvalid with outstanding=0 is a bus protocol error; ignored, counters saturate at 0.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=RESET_PC; counters 0; effective immediately on rst low.
- First cycle after reset release: mem_req=1, mem_addr=RESET_PC.
- Response-to-output latency: word pushed at edge ending the rvalid cycle; instr_valid=1 the next cycle. No bypass.
- Redirect at cycle T: mem_req=1 with mem_addr=redirect_pc at T+1 (if credits allow); with gnt at T+1, rvalid at T+2, instr_valid at T+3 with instr_pc=redirect_pc.
- Steady state with 1-cycle memory and instr_ready=1: one instruction per cycle.
- Reset mid-operation: all in-flight state lost; responses arriving after release for pre-reset requests are a system error (memory reset together).

## Test plan
- Reset release, gnt always 1, rvalid one cycle after gnt, ready=1: instr_pc sequence 0,4,8,… with data matching memory, first instr_valid 3 cycles after release.
- instr_ready=0 held: exactly DEPTH (4) grants then mem_req=0; raise ready → 4 pops, mem_req reasserts the cycle after first pop.
- mem_gnt=0 for 5 cycles: mem_req=1 and mem_addr constant; then gnt → fetch_pc advances by 4.
- 3 requests outstanding, redirect to 64'h1000: next 3 rvalids produce no instr_valid; first output instr_pc=64'h1000; redirect_pc 64'h1002 also yields 64'h1000.
- Redirect coincident with rvalid, gnt and pop: FIFO empty next cycle, response discarded, granted request dropped, instr_pc=new PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8: outputs PCs …FFF8, …FFFC, 0, 4.
